// File: rtl/custom_leds_pwm.sv
// Avalon-MM LED controller: per-channel mask and PWM duty, shared prescaler, optional blink.
// Blink logic is present only when CUSTOM_LEDS_PWM_BLINK_EN is defined.

module custom_leds_pwm_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                duty_wr,
  input  logic [PWM_BITS-1:0] wdata,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                gate,
  output logic [PWM_BITS-1:0] duty,
  output logic                led
);
  always_ff @(posedge clk) begin
    if (reset) begin
      duty <= '0;
      led  <= 1'b0;
    end else begin
      if (duty_wr) duty <= wdata;
      // all-ones duty is a full-on special case, the compare alone would drop one slot
      led <= gate & ((duty == '1) | (pwm_cnt < duty));
    end
  end
endmodule

module custom_leds_pwm #(
  parameter int NUM_LEDS   = 8,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE_W = 16,
  parameter int BLINK_W    = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_s0_address,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  output logic [31:0]       avs_s0_readdata,
  input  logic [31:0]       avs_s0_writedata,
  output logic [NUM_LEDS-1:0] leds
);
  logic                               enable, blink_en, phase_eff;
  logic [NUM_LEDS-1:0]                onmask;
  logic [PRESCALE_W-1:0]              prescale, presc_cnt;
  logic [PWM_BITS-1:0]                pwm_cnt;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty;
  logic                               wr_ctrl, wr_presc, ctrl_stop, restart, tick, period_end;
  logic                               unused_ok;

  assign wr_ctrl    = avs_s0_write && (avs_s0_address == ADDR_W'(0));
  assign wr_presc   = avs_s0_write && (avs_s0_address == ADDR_W'(2));
  assign ctrl_stop  = wr_ctrl && !avs_s0_writedata[0];
  assign restart    = wr_presc || ctrl_stop;
  assign tick       = enable && (presc_cnt == prescale);
  assign period_end = tick && (pwm_cnt == '1);
  assign unused_ok  = &{1'b0, avs_s0_writedata};

`ifdef CUSTOM_LEDS_PWM_BLINK_EN
  logic [BLINK_W-1:0] blink_period, blink_cnt;
  logic               blink_phase;
`else
  assign blink_en = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      enable       <= 1'b0;
      onmask       <= '0;
      prescale     <= '0;
`ifdef CUSTOM_LEDS_PWM_BLINK_EN
      blink_en     <= 1'b0;
      blink_period <= '0;
`endif
    end else if (avs_s0_write) begin
      case (avs_s0_address)
        ADDR_W'(0): begin
          enable <= avs_s0_writedata[0];
`ifdef CUSTOM_LEDS_PWM_BLINK_EN
          blink_en <= avs_s0_writedata[1];
`endif
        end
        ADDR_W'(1): onmask   <= avs_s0_writedata[NUM_LEDS-1:0];
        ADDR_W'(2): prescale <= avs_s0_writedata[PRESCALE_W-1:0];
`ifdef CUSTOM_LEDS_PWM_BLINK_EN
        ADDR_W'(3): blink_period <= avs_s0_writedata[BLINK_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  // timebase restarts from zero whenever prescale is rewritten or the block is stopped
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (enable) begin
      presc_cnt <= tick ? '0 : presc_cnt + PRESCALE_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

`ifdef CUSTOM_LEDS_PWM_BLINK_EN
  always_ff @(posedge clk) begin
    if (reset || !blink_en || ctrl_stop) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wr_presc) begin
      blink_cnt <= '0;
    end else if (period_end) begin
      if (blink_cnt == blink_period) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end
  // clearing blink_en lights the LEDs on the very next edge, not one later
  assign phase_eff = blink_phase | ~blink_en;
`else
  assign phase_eff = 1'b1;
`endif

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lane
    custom_leds_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .duty_wr (avs_s0_write && (avs_s0_address == ADDR_W'(4 + i))),
      .wdata   (avs_s0_writedata[PWM_BITS-1:0]),
      .pwm_cnt (pwm_cnt),
      .gate    (enable & onmask[i] & phase_eff),
      .duty    (duty[i]),
      .led     (leds[i])
    );
  end

  always_comb begin
    avs_s0_readdata = '0;
    if (avs_s0_read) begin
      case (avs_s0_address)
        ADDR_W'(0): avs_s0_readdata[1:0] = {blink_en, enable};
        ADDR_W'(1): avs_s0_readdata[NUM_LEDS-1:0] = onmask;
        ADDR_W'(2): avs_s0_readdata[PRESCALE_W-1:0] = prescale;
`ifdef CUSTOM_LEDS_PWM_BLINK_EN
        ADDR_W'(3): avs_s0_readdata[BLINK_W-1:0] = blink_period;
`endif
        default: begin
          for (int i = 0; i < NUM_LEDS; i++)
            if (avs_s0_address == ADDR_W'(4 + i)) avs_s0_readdata[PWM_BITS-1:0] = duty[i];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_custom_leds_pwm.sv
// Directed bench for custom_leds_pwm: register table, PWM timing, blink, restart and reset.
module tb_custom_leds_pwm;
  logic        clk, reset, read, write;
  logic [3:0]  address;
  logic [31:0] writedata, readdata;
  logic [7:0]  leds;
  int n_cmp = 0, n_err = 0;

  custom_leds_pwm dut (
    .clk(clk), .reset(reset), .avs_s0_address(address), .avs_s0_read(read),
    .avs_s0_write(write), .avs_s0_readdata(readdata), .avs_s0_writedata(writedata),
    .leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    address = a; read = 1'b1;
    #1 chk($sformatf("read_addr%0d", a), readdata, exp);
    read = 1'b0;
  endtask

  task automatic rd_all_zero();
    for (int a = 0; a < 12; a++) rd(4'(a), 32'h0);
    rd(4'd15, 32'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  // expected leds with ch0 duty FF, ch1 duty 0, ch2 duty 64, others 0
  function automatic logic [31:0] pat(input int pwm, input bit phase);
    logic [7:0] v;
    v = 8'h0;
    if (phase) begin
      v[0] = 1'b1;
      v[2] = (pwm < 64);
    end
    return {24'h0, v};
  endfunction

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_leds", {24'h0, leds}, 32'h0);
    rd_all_zero();

    tbl[0] = '{4'd0,  32'hFFFF_FFFE, 32'h0};
`ifdef CUSTOM_LEDS_PWM_BLINK_EN
    tbl[0].rexp = 32'h2;
`endif
    tbl[1] = '{4'd1,  32'hFFFF_FF5A, 32'h5A};
    tbl[2] = '{4'd2,  32'hDEAD_BEEF, 32'hBEEF};
    tbl[3] = '{4'd3,  32'h0001_2345, 32'h0};
`ifdef CUSTOM_LEDS_PWM_BLINK_EN
    tbl[3].rexp = 32'h2345;
`endif
    tbl[4] = '{4'd4,  32'h0000_01FF, 32'hFF};
    tbl[5] = '{4'd11, 32'h0000_ABCD, 32'hCD};
    tbl[6] = '{4'd12, 32'hFFFF_FFFF, 32'h0};
    tbl[7] = '{4'd15, 32'hFFFF_FFFF, 32'h0};
    for (int i = 0; i < 8; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr, tbl[i].rexp);
    end

    address = 4'd2; read = 1'b0;
    #1 chk("read_idle_zero", readdata, 32'h0);

    // same-cycle read+write returns the old value
    @(negedge clk);
    address = 4'd2; read = 1'b1; write = 1'b1; writedata = 32'h7;
    #1 chk("rw_old", readdata, 32'hBEEF);
    @(negedge clk);
    write = 1'b0;
    #1 chk("rw_new", readdata, 32'h7);
    read = 1'b0;

    reset = 1'b1;
    @(negedge clk);
    chk("reset2_leds", {24'h0, leds}, 32'h0);
    reset = 1'b0;
    rd_all_zero();

    // PWM with prescale 0: 256-cycle period
    wr(4'd1, 32'hFF); wr(4'd4, 32'hFF); wr(4'd5, 32'h0); wr(4'd6, 32'd64);
    wr(4'd2, 32'h0);  wr(4'd0, 32'h1);
    for (int n = 1; n <= 512; n++) begin
      @(negedge clk);
      chk($sformatf("pwm_p0_n%0d", n), {24'h0, leds}, pat((n - 1) % 256, 1'b1));
    end

    // prescale 3: 1024-cycle period
    wr(4'd2, 32'd3);
    for (int n = 1; n <= 1100; n++) begin
      @(negedge clk);
      chk($sformatf("pwm_p3_n%0d", n), {24'h0, leds}, pat(((n - 1) / 4) % 256, 1'b1));
    end

`ifdef CUSTOM_LEDS_PWM_BLINK_EN
    wr(4'd0, 32'h0); wr(4'd2, 32'h0); wr(4'd3, 32'h1); wr(4'd0, 32'h3);
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      chk($sformatf("blink_n%0d", n), {24'h0, leds}, pat((n - 1) % 256, ((n - 1) / 512) % 2 == 0));
    end
    wr(4'd0, 32'h1);
    chk("blink_off_edge", {24'h0, leds}, 32'h0);
    @(negedge clk);
    chk("blink_resume", {24'h0, leds}, 32'h01);
`endif

    // stop mid-period, then restart from pwm 0
    wr(4'd2, 32'h0);
    repeat (10) @(negedge clk);
    wr(4'd0, 32'h0);
    @(negedge clk);
    chk("stop_leds_a", {24'h0, leds}, 32'h0);
    @(negedge clk);
    chk("stop_leds_b", {24'h0, leds}, 32'h0);
    wr(4'd0, 32'h1);
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      chk($sformatf("restart_n%0d", n), {24'h0, leds}, pat(n - 1, 1'b1));
    end

    // reset mid-pattern
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset3_leds", {24'h0, leds}, 32'h0);
    reset = 1'b0;
    rd_all_zero();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
